regfile_dump_reader: RTL and testbench

//  Reader-side engine for the 32x32 RegisterFile. On Start it sweeps registers FIRST_REG..LAST_REG
//  two at a time, using both read ports, and streams each pair out over a valid/ready interface.

---
 rtl/regfile_dump_pkg.sv | 12 +
 rtl/regfile_dump_csum.sv | 23 ++
 rtl/regfile_dump_reader.sv | 128 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types and default widths for the register-file dump reader.
package regfile_dump_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } dumpState_t;
endpackage

// File: rtl/regfile_dump_csum.sv
// XOR accumulator over dumped register data; built only with REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_csum #(
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Clear,
   input  logic              Accum,
   input  logic [DATA_W-1:0] Data1,
   input  logic [DATA_W-1:0] Data2,
   input  logic              Lane2Vld,
   output logic [DATA_W-1:0] Checksum
);
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Checksum <= '0;
      end else if (Clear) begin
         Checksum <= '0;
      end else if (Accum) begin
         Checksum <= Checksum ^ Data1 ^ (Lane2Vld ? Data2 : '0);
      end
   end
endmodule

// File: rtl/regfile_dump_reader.sv
// Sweeps FIRST_REG..LAST_REG two registers at a time and streams pairs over valid/ready.
// Define REGFILE_DUMP_CHECKSUM_EN to build the XOR checksum of dumped data.
//
// state | meaning
// IDLE  | waiting for Start
// READ  | read ports driven from ptr, pair captured at the edge
// HOLD  | pair presented, waiting for OutReady
// DONE  | one-cycle Done pulse after the final pair
module regfile_dump_reader
   import regfile_dump_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int FIRST_REG = 8,
   parameter int LAST_REG  = 25
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start,
   input  logic              Abort,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] ReadRegister1,
   output logic [ADDR_W-1:0] ReadRegister2,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [ADDR_W-1:0] OutAddr1,
   output logic [DATA_W-1:0] OutData1,
   output logic [ADDR_W-1:0] OutAddr2,
   output logic [DATA_W-1:0] OutData2,
   output logic              OutLane2Vld,
   output logic [DATA_W-1:0] Checksum
);
   // ptr carries one extra bit so ptr+2 cannot wrap when LAST_REG is the top register.
   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] FirstPtr = PW'(FIRST_REG);
   localparam logic [PW-1:0] LastPtr  = PW'(LAST_REG);

   dumpState_t        state, stateNxt;
   logic [PW-1:0]     ptr, ptrP1, ptrP2;
   logic [ADDR_W-1:0] rdAddr2;
   logic              lane2Ok, isLast, startDump, handshake;

   assign ptrP1     = ptr + PW'(1);
   assign ptrP2     = ptr + PW'(2);
   assign lane2Ok   = (ptrP1 <= LastPtr);
   assign isLast    = (ptrP2 > LastPtr);
   assign rdAddr2   = lane2Ok ? ptrP1[ADDR_W-1:0] : ptr[ADDR_W-1:0];
   assign startDump = (state == IDLE) && Start && !Abort;
   assign handshake = (state == HOLD) && OutReady && !Abort;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNxt;
      end
   end

   always_comb begin
      stateNxt      = state;
      Busy          = 1'b1;
      Done          = 1'b0;
      ReadRegister1 = '0;
      ReadRegister2 = '0;
      case (state)
         IDLE: begin
            Busy = 1'b0;
            if (startDump) stateNxt = READ;
         end
         READ: begin
            ReadRegister1 = ptr[ADDR_W-1:0];
            ReadRegister2 = rdAddr2;
            stateNxt      = Abort ? IDLE : HOLD;
         end
         HOLD: begin
            if (Abort)          stateNxt = IDLE;
            else if (handshake) stateNxt = isLast ? DONE : READ;
         end
         DONE: begin
            Done     = 1'b1;
            stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ptr         <= '0;
         OutValid    <= 1'b0;
         OutAddr1    <= '0;
         OutAddr2    <= '0;
         OutData1    <= '0;
         OutData2    <= '0;
         OutLane2Vld <= 1'b0;
      end else begin
         if (startDump) ptr <= FirstPtr;
         if (state == READ && !Abort) begin
            OutValid    <= 1'b1;
            OutAddr1    <= ptr[ADDR_W-1:0];
            OutAddr2    <= rdAddr2;
            OutData1    <= ReadData1;
            OutData2    <= ReadData2;
            OutLane2Vld <= lane2Ok;
         end
         if (state == HOLD && (Abort || handshake)) OutValid <= 1'b0;
         if (handshake && !isLast) ptr <= ptrP2;
      end
   end

`ifdef REGFILE_DUMP_CHECKSUM_EN
   regfile_dump_csum #(.DATA_W(DATA_W)) uCsum (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Clear    (startDump),
      .Accum    (handshake),
      .Data1    (OutData1),
      .Data2    (OutData2),
      .Lane2Vld (OutLane2Vld),
      .Checksum (Checksum)
   );
`else
   assign Checksum = '0;
`endif
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: three instances over different register ranges sharing one register array.
module tb_regfile_dump_reader;
   localparam int NDUT = 3;

   function automatic int firstOf(input int g);
      return (g == 0) ? 8 : ((g == 1) ? 21 : 31);
   endfunction
   function automatic int lastOf(input int g);
      return (g == 0) ? 25 : 31;
   endfunction

   typedef struct {
      int          a1;
      logic [31:0] d1;
      int          a2;
      logic [31:0] d2;
      bit          l2;
   } pair_t;

   typedef struct {
      int          dut;
      int          rdyPct;
      int          pat;
      int          nPairs;
      int          lastA1;
      bit          lastL2;
      bit          csKnown;
      logic [31:0] csVal;
   } vec_t;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   logic [31:0] regs [32];

   logic [NDUT-1:0]       start, abort, ready, busy, done, vld, l2;
   logic [NDUT-1:0][4:0]  rr1, rr2, oa1, oa2;
   logic [NDUT-1:0][31:0] rd1, rd2, od1, od2, cs;

   for (genvar g = 0; g < NDUT; g++) begin : gDut
      assign rd1[g] = regs[rr1[g]];
      assign rd2[g] = regs[rr2[g]];
      regfile_dump_reader #(
         .DATA_W(32), .ADDR_W(5), .FIRST_REG(firstOf(g)), .LAST_REG(lastOf(g))
      ) dut (
         .Clk(Clk), .Rst_n(Rst_n), .Start(start[g]), .Abort(abort[g]),
         .Busy(busy[g]), .Done(done[g]),
         .ReadRegister1(rr1[g]), .ReadRegister2(rr2[g]),
         .ReadData1(rd1[g]), .ReadData2(rd2[g]),
         .OutValid(vld[g]), .OutReady(ready[g]),
         .OutAddr1(oa1[g]), .OutData1(od1[g]), .OutAddr2(oa2[g]), .OutData2(od2[g]),
         .OutLane2Vld(l2[g]), .Checksum(cs[g])
      );
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic bit allZero();
      return busy == '0 && done == '0 && vld == '0 && l2 == '0 && rr1 == '0 && rr2 == '0 &&
             oa1 == '0 && oa2 == '0 && od1 == '0 && od2 == '0 && cs == '0;
   endfunction

   function automatic logic [127:0] snap(input int d);
      return {53'd0, oa1[d], oa2[d], l2[d], od1[d], od2[d]};
   endfunction

   task automatic loadPattern(input int p);
      for (int n = 0; n < 32; n++) begin
         case (p)
            0, 3:    regs[n] = 32'h100 + n;
            1:       regs[n] = 32'h200 + n;
            default: regs[n] = $urandom;
         endcase
      end
      if (p == 1) begin
         regs[21] = 32'h14;
         regs[31] = 32'd1000;
      end
      if (p == 3) regs[8] = 32'hABCDEF98;
   endtask

   // Full dump with random back-pressure and spurious Start, checked pair by pair against a list model.
   task automatic runDump(input int d, input int rdyPct, output int nHs, output int lastA1,
                          output bit lastL2, output logic [31:0] csDone, output bit gotDone);
      pair_t       expQ[$];
      logic [31:0] csExp = '0;
      logic [127:0] held = '0;
      bit          holding = 0;
      int          lastHsCyc = -10;
      int          f = firstOf(d);
      int          l = lastOf(d);
      for (int a = f; a <= l; a += 2) begin
         pair_t p;
         p.a1 = a;
         p.d1 = regs[a];
         p.l2 = (a + 1 <= l);
         p.a2 = p.l2 ? a + 1 : a;
         p.d2 = regs[p.a2];
         expQ.push_back(p);
         csExp ^= p.d1 ^ (p.l2 ? p.d2 : 32'd0);
      end
      nHs = 0; lastA1 = -1; lastL2 = 0; csDone = '0; gotDone = 0;
      @(negedge Clk); start[d] = 1'b1; ready[d] = 1'b0;
      @(negedge Clk); start[d] = 1'b0;
      chk(busy[d] && !vld[d], "start_latency_read", {busy[d], vld[d]}, 2'b10);
      @(negedge Clk);
      chk(vld[d] == 1'b1, "first_valid", vld[d], 1);
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (done[d]) begin
            start[d] = 1'b0;
            gotDone = 1;
            csDone = cs[d];
            chk(nHs == expQ.size() && lastHsCyc == cyc - 1, "done_timing", nHs, expQ.size());
`ifdef REGFILE_DUMP_CHECKSUM_EN
            chk(cs[d] == csExp, "checksum", cs[d], csExp);
`else
            chk(cs[d] == 32'd0, "checksum_tied", cs[d], 0);
`endif
            break;
         end
         if (vld[d]) begin
            if (holding) chk(snap(d) == held, "hold_stable", snap(d), held);
            ready[d] = ($urandom_range(99) < rdyPct);
            if (ready[d]) begin
               if (nHs < expQ.size()) begin
                  pair_t e = expQ[nHs];
                  bit ok = (oa1[d] == e.a1[4:0]) && (od1[d] == e.d1) && (l2[d] == e.l2) &&
                           (!e.l2 || (oa2[d] == e.a2[4:0] && od2[d] == e.d2));
                  chk(ok, "pair", {oa1[d], od1[d], oa2[d], od2[d], l2[d]},
                      {e.a1[4:0], e.d1, e.a2[4:0], e.d2, e.l2});
               end else begin
                  chk(0, "extra_pair", nHs, expQ.size());
               end
               nHs++; lastHsCyc = cyc; lastA1 = oa1[d]; lastL2 = l2[d]; holding = 0;
            end else begin
               holding = 1;
               held = snap(d);
            end
         end else begin
            ready[d] = 1'($urandom_range(1));
         end
         start[d] = 1'($urandom_range(1));
         @(negedge Clk);
      end
      start[d] = 1'b0;
      ready[d] = 1'b0;
      if (!gotDone) chk(0, "done_timeout", nHs, expQ.size());
      @(negedge Clk);
      chk(!done[d] && !busy[d], "done_single_pulse", {done[d], busy[d]}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[7];
      int          nHs, lastA1;
      bit          lastL2, gotDone, aborted, saw;
      logic [31:0] csDone;
      logic [127:0] s;
      int          hs;

      tbl[0] = '{0, 100, 0, 9, 24, 1, 1, 32'h00000001};
      tbl[1] = '{1, 100, 1, 6, 31, 0, 0, 32'h0};
      tbl[2] = '{2, 60,  2, 1, 31, 0, 0, 32'h0};
      tbl[3] = '{0, 35,  2, 9, 24, 1, 0, 32'h0};
      tbl[4] = '{1, 50,  2, 6, 31, 0, 0, 32'h0};
      tbl[5] = '{0, 100, 3, 9, 24, 1, 1, 32'hABCDEE91};
      tbl[6] = '{2, 100, 3, 1, 31, 0, 1, 32'h0000011F};

      start = '0; abort = '0; ready = '0;
      loadPattern(0);
      repeat (2) @(negedge Clk);
      chk(allZero(), "reset_state", {busy, vld, done}, 0);
      Rst_n = 1'b1;
      @(negedge Clk);

      // Abort together with Start in IDLE keeps the engine idle.
      start[0] = 1'b1; abort[0] = 1'b1;
      @(negedge Clk);
      start[0] = 1'b0; abort[0] = 1'b0;
      chk(!busy[0], "abort_with_start", busy[0], 0);

      // Back-pressure: pair must hold for 5 cycles, then the next pair follows from the same ptr.
      @(negedge Clk); start[0] = 1'b1;
      @(negedge Clk); start[0] = 1'b0;
      for (int i = 0; i < 10 && !vld[0]; i++) @(negedge Clk);
      s = snap(0);
      chk(vld[0] && oa1[0] == 5'd8, "stall_first_pair", oa1[0], 8);
      repeat (5) begin
         @(negedge Clk);
         chk(snap(0) == s && vld[0] && busy[0] && !done[0], "stall_hold", snap(0), s);
      end
      ready[0] = 1'b1;
      @(negedge Clk); ready[0] = 1'b0;
      for (int i = 0; i < 10 && !vld[0]; i++) @(negedge Clk);
      chk(vld[0] && oa1[0] == 5'd10 && od1[0] == 32'h10A, "stall_next_pair", {oa1[0], od1[0]}, {5'd10, 32'h10A});
      abort[0] = 1'b1;
      @(negedge Clk); abort[0] = 1'b0;
      chk(!busy[0] && !vld[0], "abort_in_hold", {busy[0], vld[0]}, 0);

      // Abort on the same cycle as the third handshake.
      @(negedge Clk); start[0] = 1'b1;
      @(negedge Clk); start[0] = 1'b0; ready[0] = 1'b1;
      hs = 0; aborted = 0;
      for (int i = 0; i < 40 && !aborted; i++) begin
         if (vld[0]) begin
            if (hs == 2) begin
               abort[0] = 1'b1;
               aborted = 1;
            end
            hs++;
         end
         @(negedge Clk);
      end
      abort[0] = 1'b0; ready[0] = 1'b0;
      chk(aborted && !busy[0] && !vld[0] && !done[0], "abort_with_handshake", {aborted, busy[0], vld[0], done[0]}, 4'b1000);
      saw = 0;
      repeat (8) begin
         @(negedge Clk);
         if (done[0] || busy[0]) saw = 1;
      end
      chk(!saw, "abort_no_done", saw, 0);
      runDump(0, 80, nHs, lastA1, lastL2, csDone, gotDone);
      chk(gotDone && nHs == 9, "restart_after_abort", nHs, 9);

      // Reset in the middle of a dump, while ports are being driven.
      loadPattern(1);
      @(negedge Clk); start[1] = 1'b1;
      @(negedge Clk); start[1] = 1'b0; ready[1] = 1'b1;
      for (int i = 0; i < 10 && !vld[1]; i++) @(negedge Clk);
      @(negedge Clk); ready[1] = 1'b0;
      chk(busy[1] && !vld[1] && rr1[1] == 5'd23 && rr2[1] == 5'd24, "read_ports", {rr1[1], rr2[1]}, {5'd23, 5'd24});
      #2 Rst_n = 1'b0;
      #1 chk(allZero(), "async_reset", {busy, vld, oa1, od1}, 0);
      @(negedge Clk); @(negedge Clk);
      Rst_n = 1'b1;
      saw = 0;
      repeat (5) begin
         @(negedge Clk);
         if (busy != '0 || vld != '0) saw = 1;
      end
      chk(!saw, "idle_after_reset", saw, 0);

      for (int v = 0; v < 7; v++) begin
         loadPattern(tbl[v].pat);
         runDump(tbl[v].dut, tbl[v].rdyPct, nHs, lastA1, lastL2, csDone, gotDone);
         chk(gotDone && nHs == tbl[v].nPairs && lastA1 == tbl[v].lastA1 && lastL2 == tbl[v].lastL2,
             $sformatf("vec%0d_shape", v), {nHs, lastA1, lastL2}, {tbl[v].nPairs, tbl[v].lastA1, tbl[v].lastL2});
`ifdef REGFILE_DUMP_CHECKSUM_EN
         if (tbl[v].csKnown) chk(csDone == tbl[v].csVal, $sformatf("vec%0d_csum", v), csDone, tbl[v].csVal);
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
